// File: rtl/uart_doc_loader_pkg.sv
// Shared types and constants for the UART document loader.
// Optional feature macro: RX_PARITY_EN (adds an even-parity bit after the data bits).
package uart_doc_pkg;

    // Receiver FSM states; PARITY only exists when the parity bit is part of the frame
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_WRITE  = 3'd5
    } rx_state_t;

    // Control bytes recognised by the loader
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // Printable range written into the document
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // Cursor field widths; document address is {row, col}
    localparam int ROW_W = 4;
    localparam int COL_W = 5;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/uart_doc_loader_if.sv
// Document write port: address {row, col}, data byte and one-cycle write strobe.
interface uart_doc_loader_if;
    import uart_doc_pkg::*;

    logic [ROW_W+COL_W-1:0] doc_a;
    logic [7:0]             doc_d;
    logic                   doc_we;

    modport master (output doc_a, output doc_d, output doc_we);
    modport slave  (input  doc_a, input  doc_d, input  doc_we);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: input synchronizer, baud counter and framing FSM.
// Emits byte_valid combinationally at the stop-bit sample (the FSM enters WRITE on
// that same edge) and a registered frame_err pulse one cycle after a bad stop sample.
// Optional feature macro: RX_PARITY_EN (8E1 framing instead of 8N1).
module uart_rx_core
    import uart_doc_pkg::*;
#(
    parameter int BIT_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    localparam int HALF  = BIT_DIV / 2;
    localparam int CNT_W = $clog2(BIT_DIV + 1);

    rx_state_t        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             half_tick, full_tick, parity_ok, stop_good;

`ifdef RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    assign parity_ok = ~parity_err_q;
`else
    assign parity_ok = 1'b1;
`endif

    assign half_tick = (baud_cnt_q == CNT_W'(HALF - 1));
    assign full_tick = (baud_cnt_q == CNT_W'(BIT_DIV - 1));
    assign stop_good = sync2_q & parity_ok;

    // State register plus synchronizer and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= rx_i;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
`ifdef RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state and datapath: sample at half-bit for START, full bit thereafter
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_err_d  = 1'b0;
`ifdef RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
`ifdef RX_PARITY_EN
                parity_err_d = 1'b0;
`endif
                if (prev_q && !sync2_q) state_d = ST_START;
            end
            ST_START: begin
                if (half_tick) begin
                    baud_cnt_d = '0;
                    state_d    = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    baud_cnt_d = '0;
                    shift_d    = {sync2_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (full_tick) begin
                    baud_cnt_d   = '0;
                    parity_err_d = (^shift_q) ^ sync2_q;
                    state_d      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_tick) begin
                    baud_cnt_d = '0;
                    if (stop_good) begin
                        state_d = ST_WRITE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Outputs: byte strobe at the good stop sample, busy while framing
    always_comb begin
        byte_o       = shift_q;
        byte_valid_o = (state_q == ST_STOP) && full_tick && stop_good;
        frame_err_o  = frame_err_q;
        busy_o       = (state_q != ST_IDLE);
    end

endmodule

// File: rtl/uart_doc_loader.sv
// UART-to-document loader: received bytes become character writes at a text cursor,
// with newline, backspace and wrap handling over a COLS x ROWS grid.
// Optional feature macro: RX_PARITY_EN (handled inside uart_rx_core).
module uart_doc_loader
    import uart_doc_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int COLS     = 20,
    parameter int ROWS     = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RsRx,
    input  logic                  en,
    input  logic                  clear_cursor,
    uart_doc_loader_if.master     doc_if,
    output logic                  busy,
    output logic                  frame_err
);
    localparam int BIT_DIV = CLK_FREQ / BAUD;

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic [ROW_W-1:0] row_q, row_d, row_plus;
    logic [COL_W-1:0] col_q, col_d, col_minus;
    logic             doc_we_q, doc_we_d;
    logic [ROW_W+COL_W-1:0] doc_a_q, doc_a_d;
    logic [7:0]       doc_d_q, doc_d_d;

    uart_rx_core #(.BIT_DIV(BIT_DIV)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (RsRx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    assign row_plus  = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    assign col_minus = col_q - COL_W'(1);

    // Cursor and registered write port; the write lands in the rx WRITE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            doc_we_q <= 1'b0;
            doc_a_q  <= '0;
            doc_d_q  <= '0;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            doc_we_q <= doc_we_d;
            doc_a_q  <= doc_a_d;
            doc_d_q  <= doc_d_d;
        end
    end

    // Byte interpretation; clear_cursor overrides the cursor but not the write address
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        doc_we_d = 1'b0;
        doc_a_d  = doc_a_q;
        doc_d_d  = doc_d_q;
        if (rx_valid && en) begin
            if (is_printable(rx_byte)) begin
                doc_we_d = 1'b1;
                doc_a_d  = {row_q, col_q};
                doc_d_d  = rx_byte;
                if (col_q == COL_W'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_plus;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else if (rx_byte == CH_LF) begin
                col_d = '0;
                row_d = row_plus;
            end else if (rx_byte == CH_BS && col_q != '0) begin
                col_d    = col_minus;
                doc_we_d = 1'b1;
                doc_a_d  = {row_q, col_minus};
                doc_d_d  = CH_SPACE;
            end
        end
        if (clear_cursor) begin
            row_d = '0;
            col_d = '0;
        end
    end

    // Drive the document port from the registered write fields
    always_comb begin
        doc_if.doc_we = doc_we_q;
        doc_if.doc_a  = doc_a_q;
        doc_if.doc_d  = doc_d_q;
    end

endmodule

// File: tb/tb_uart_doc_loader.sv
// Scoreboard bench for uart_doc_loader: expected writes are queued at stimulus time
// and a monitor pops/compares on every doc_we. Uses a 64-cycle bit period.
module tb_uart_doc_loader;
    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_DIV  = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RsRx = 1'b1;
    logic en = 1'b1;
    logic clear_cursor = 1'b0;
    logic busy, frame_err;

    uart_doc_loader_if doc_if();

    uart_doc_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .COLS(20), .ROWS(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .RsRx         (RsRx),
        .en           (en),
        .clear_cursor (clear_cursor),
        .doc_if       (doc_if),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fe_cnt = 0;
    logic fe_prev = 1'b0;
    logic [16:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [16:0] wr(input int row, input int col, input logic [7:0] d);
        logic [3:0] r;
        logic [4:0] c;
        r = 4'(row);
        c = 5'(col);
        return {r, c, d};
    endfunction

    // Monitor: every write strobe must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && doc_if.doc_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {15'd0, doc_if.doc_a, doc_if.doc_d}, 32'h1FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("doc_write", {15'd0, doc_if.doc_a, doc_if.doc_d}, {15'd0, e});
                $display("write a=0x%03h d=0x%02h", doc_if.doc_a, doc_if.doc_d);
            end
        end
        if (!rst && frame_err) begin
            fe_cnt++;
            if (fe_prev) chk("frame_err_width", 32'd2, 32'd1);
        end
        fe_prev = frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        RsRx = 1'b0;
        wait_cyc(BIT_DIV);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            wait_cyc(BIT_DIV);
        end
`ifdef RX_PARITY_EN
        RsRx = ^b;
        wait_cyc(BIT_DIV);
`endif
        RsRx = good_stop;
        wait_cyc(BIT_DIV);
        RsRx = 1'b1;
        wait_cyc(2 * BIT_DIV);
        $display("sent 0x%02h stop=%0b", b, good_stop);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    initial begin
        int n;
        int fe_before;

        // Reset state
        wait_cyc(4);
        @(negedge clk);
        chk("rst_doc_we", {31'd0, doc_if.doc_we}, 32'd0);
        chk("rst_doc_a", {23'd0, doc_if.doc_a}, 32'd0);
        chk("rst_doc_d", {24'd0, doc_if.doc_d}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_cyc(10);

        // Single printable byte at the origin
        exp_q.push_back(wr(0, 0, 8'h41));
        send_ok(8'h41);
        chk("busy_after_byte", {31'd0, busy}, 32'd0);

        // Clear cursor, fill a row and wrap
        clear_cursor = 1'b1;
        wait_cyc(1);
        clear_cursor = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(wr(0, i, 8'h78));
            send_ok(8'h78);
        end
        exp_q.push_back(wr(1, 0, 8'h79));
        send_ok(8'h79);

        // LF to row 2, five chars to col 5, BS then LF
        send_ok(8'h0A);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(wr(2, i, 8'h61 + 8'(i)));
            send_ok(8'h61 + 8'(i));
        end
        exp_q.push_back(wr(2, 4, 8'h20));
        send_ok(8'h08);
        send_ok(8'h0A);
        exp_q.push_back(wr(3, 0, 8'h5A));
        send_ok(8'h5A);

        // Non-printable ignored, disabled loader drops bytes without moving cursor
        send_ok(8'h01);
        en = 1'b0;
        send_ok(8'h51);
        en = 1'b1;
        exp_q.push_back(wr(3, 1, 8'h52));
        send_ok(8'h52);

        // Bad stop bit: frame error, no write, next byte normal
        fe_before = fe_cnt;
        send_byte(8'h4B, 1'b0);
        chk("frame_err_count", 32'(fe_cnt), 32'(fe_before + 1));
        chk("busy_after_ferr", {31'd0, busy}, 32'd0);
        exp_q.push_back(wr(3, 2, 8'h4C));
        send_ok(8'h4C);

        // Short low glitch: busy rises then falls at the half-bit re-sample
        RsRx = 1'b0;
        wait_cyc(5);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        wait_cyc(15);
        RsRx = 1'b1;
        n = 20;
        while (busy && n < 200) begin
            wait_cyc(1);
            n++;
        end
        chk("glitch_busy_fall", {31'd0, (n >= 33 && n <= 37)}, 32'd1);
        $display("glitch busy fell after %0d cycles", n);
        wait_cyc(2 * BIT_DIV);

        // Reset in the middle of a frame
        RsRx = 1'b0;
        wait_cyc(BIT_DIV);
        for (int i = 0; i < 4; i++) begin
            RsRx = 1'b1;
            wait_cyc(BIT_DIV);
        end
        rst = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        chk("midrst_doc_we", {31'd0, doc_if.doc_we}, 32'd0);
        chk("midrst_doc_a", {23'd0, doc_if.doc_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        RsRx = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2 * BIT_DIV);
        exp_q.push_back(wr(0, 0, 8'h4D));
        send_ok(8'h4D);

        // Drain and final bookkeeping
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            wait_cyc(1);
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_err_total", 32'(fe_cnt), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_doc_loader.md
UART_DOC_LOADER -- requirements
Module: uart_doc_loader

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: serial bit rate; bit period BIT_DIV = CLK_FREQ/BAUD cycles (868 at the defaults).
REQ-003 Parameter COLS, default 20: text columns per row, matching the 32-pixel block grid.
REQ-004 Parameter ROWS, default 15: text rows.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 RsRx  in  1  asynchronous UART serial input; idles high.
REQ-008 en  in  1  loader enable; bytes that complete while low are dropped.
REQ-009 clear_cursor  in  1  one-cycle pulse that returns the cursor to row 0, col 0.
REQ-010 doc_a  out  9  document write address {row[3:0], col[4:0]}.
REQ-011 doc_d  out  8  document write data.
REQ-012 doc_we  out  1  one-cycle document write strobe.
REQ-013 busy  out  1  high from start-bit detection to completion of the byte's processing.
REQ-014 frame_err  out  1  one-cycle pulse on a bad stop bit (or bad parity when enabled).

Function
REQ-015 RsRx SHALL pass through a 2-flop synchronizer (reset to 1) before any use.
REQ-016 RX FSM states: IDLE, START, DATA, [PARITY], STOP, WRITE.
- IDLE -> START on a synchronized falling edge.
- START re-samples at BIT_DIV/2; line high -> IDLE (glitch); line low -> DATA.
REQ-017 DATA SHALL sample 8 bits LSB-first, each exactly BIT_DIV cycles after the previous sample; a 3-bit counter wraps from 7 to 0 on exit.
REQ-018 STOP sample high -> WRITE; sample low -> frame_err pulse, byte discarded, FSM -> IDLE with no write.
REQ-019 WRITE lasts 1 cycle; doc_we, doc_a and doc_d SHALL be valid together exactly 1 cycle after the stop-bit sample.
REQ-020 Byte handling, keyed on the byte value:
- 0x20-0x7E: write at the cursor, then col+1.
- 0x0A: no write; col=0, row+1.
- 0x08: if col>0, col-1, then write 0x20 at the new cursor; if col=0, no action.
- All other bytes: ignored, no write.
REQ-021 Cursor wrap: col reaching COLS -> col=0, row+1; row reaching ROWS -> row=0. The cursor never holds col>=COLS or row>=ROWS.
REQ-022 With en=0 the RX FSM still runs (so it stays framed), but WRITE performs no write and no cursor update.
REQ-023 When clear_cursor coincides with a WRITE cycle, the write goes to the old cursor and the cursor ends at 0,0.
REQ-024 busy SHALL fall in the cycle after WRITE, or on leaving STOP or START through the error or glitch path.

Reset
REQ-025 While rst is high, outputs are held as follows:
- FSM=IDLE, cursor=0,0, bit and baud counters=0.
- doc_we=0, doc_a=0, doc_d=0, busy=0, frame_err=0.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no write; the next falling edge after reset release starts a new frame.

Configuration
REQ-027 With RX_PARITY_EN defined, a PARITY state samples an even-parity bit after DATA; on mismatch, frame_err pulses at the stop sample and the byte is discarded.
REQ-028 Without RX_PARITY_EN, the frame is 8N1 and no PARITY state exists.

Structure
REQ-029 Shared package uart_doc_pkg SHALL hold:
- the FSM state typedef;
- control byte constants (LF=0x0A, BS=0x08, SPACE=0x20);
- the printable range bounds.
REQ-030 Sub-module uart_rx_core SHALL contain the synchronizer, baud counter and RX FSM, and emit byte plus byte_valid/err pulses; the top of the block holds the cursor and write logic.

Verification
REQ-031 Send 'A' (0x41) at 115200 from reset -> doc_we 1 cycle, doc_a=0x000, doc_d=0x41, then cursor col=1.
REQ-032 Send 20 × 'x', then 'y' -> the 21st write has doc_a={4'd1,5'd0}.
REQ-033 With cursor at row 2, col 5, send 0x08 -> write 0x20 at {2,4}; send 0x0A -> no write, cursor {3,0}.
REQ-034 Hold the stop bit low -> frame_err 1 cycle, no doc_we, busy falls; the next valid byte is written normally.
REQ-035 Apply a 200-cycle low glitch on RsRx -> no frame, busy falls at the BIT_DIV/2 re-sample, no write.
REQ-036 Assert rst at bit 4 of a frame -> no write, all outputs 0; a byte sent after release is written at 0x000.
